// File: rtl/neo_spike_detector_if.sv
// Sample/event bus of the NEO spike detector.
// master drives Enable/Data_in/Scale/Refractory; slave returns events.
interface neo_spike_detector_if;
  logic               Enable;
  logic signed [15:0] Data_in;
  logic        [3:0]  Scale;
  logic        [7:0]  Refractory;
  logic               Spike;
  logic signed [15:0] Spike_peak;
  logic        [15:0] Spike_index;
  logic signed [15:0] Thresh;
  logic               Thresh_valid;
  logic        [7:0]  Spike_count;

  modport master (
    output Enable, Data_in, Scale, Refractory,
    input  Spike, Spike_peak, Spike_index,
    input  Thresh, Thresh_valid, Spike_count
  );

  modport slave (
    input  Enable, Data_in, Scale, Refractory,
    output Spike, Spike_peak, Spike_index,
    output Thresh, Thresh_valid, Spike_count
  );
endinterface

// File: rtl/neo_spike_detector.sv
// Adaptive-threshold spike detector on a NEO energy stream.
// Ports: clk, rst (sync, active high), bus (slave): samples in, events out.
module neo_spike_detector (
  input  logic                clk,
  input  logic                rst,
  neo_spike_detector_if.slave bus
);

  typedef enum logic [1:0] {
    TRAIN, ARMED, IN_SPIKE, REFRACT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [23:0] acc_q, acc_d;
  logic [15:0] thr_q, thr_d;
  logic        tv_q, tv_d;
  logic [15:0] peak_q, peak_d;
  logic [15:0] pidx_q, pidx_d;
  logic [5:0]  len_q, len_d;
  logic [7:0]  refr_q, refr_d;
  logic        spk_q, spk_d;
  logic [15:0] speak_q, speak_d;
  logic [15:0] sidx_q, sidx_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [15:0] samp;
  logic [23:0] sum;
  logic [3:0]  scale_eff;
  logic [19:0] prod;
  logic [15:0] thr_new;
  logic        blk_end;
  logic        above;
  logic        end_spk;

  always_comb begin
    samp      = bus.Data_in[15] ? 16'd0 : bus.Data_in;
    sum       = acc_q + {8'd0, samp};
    // index starts at 0 and wraps at a multiple of 256,
    // so its low byte is the position inside the block
    blk_end   = (idx_q[7:0] == 8'hff);
    scale_eff = (bus.Scale == 4'd0) ? 4'd1 : bus.Scale;
    prod      = {4'd0, sum[23:8]} * {16'd0, scale_eff};
    thr_new   = (prod > 20'd32767) ? 16'h7fff : prod[15:0];
    above     = (samp > thr_q);

    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    thr_d   = thr_q;
    tv_d    = tv_q;
    peak_d  = peak_q;
    pidx_d  = pidx_q;
    len_d   = len_q;
    refr_d  = refr_q;
    spk_d   = 1'b0;
    speak_d = speak_q;
    sidx_d  = sidx_q;
    cnt_d   = cnt_q;
    end_spk = 1'b0;

    if (bus.Enable) begin
      idx_d = idx_q + 16'd1;
      acc_d = blk_end ? 24'd0 : sum;
      if (blk_end) begin
        thr_d = thr_new;
        tv_d  = 1'b1;
      end
      unique case (state_q)
        TRAIN: begin
          if (blk_end) state_d = ARMED;
        end
        ARMED: begin
          if (above) begin
            state_d = IN_SPIKE;
            peak_d  = samp;
            pidx_d  = idx_q;
            len_d   = 6'd1;
          end
        end
        IN_SPIKE: begin
          if (!above) begin
            end_spk = 1'b1;
          end else begin
            if (samp > peak_q) begin
              peak_d = samp;
              pidx_d = idx_q;
            end
            len_d = len_q + 6'd1;
            // len_q counts samples already in the spike
            if (len_q == 6'd63) end_spk = 1'b1;
          end
        end
        REFRACT: begin
          refr_d = (refr_q == 8'd0) ? 8'd0 : refr_q - 8'd1;
          if (refr_q <= 8'd1) state_d = ARMED;
        end
      endcase
      if (end_spk) begin
        spk_d   = 1'b1;
        speak_d = peak_d;
        sidx_d  = pidx_d;
        if (cnt_q != 8'hff) cnt_d = cnt_q + 8'd1;
        if (bus.Refractory == 8'd0) begin
          state_d = ARMED;
        end else begin
          state_d = REFRACT;
          refr_d  = bus.Refractory;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TRAIN;
      idx_q   <= '0;
      acc_q   <= '0;
      thr_q   <= '0;
      tv_q    <= 1'b0;
      peak_q  <= '0;
      pidx_q  <= '0;
      len_q   <= '0;
      refr_q  <= '0;
      spk_q   <= 1'b0;
      speak_q <= '0;
      sidx_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      thr_q   <= thr_d;
      tv_q    <= tv_d;
      peak_q  <= peak_d;
      pidx_q  <= pidx_d;
      len_q   <= len_d;
      refr_q  <= refr_d;
      spk_q   <= spk_d;
      speak_q <= speak_d;
      sidx_q  <= sidx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.Spike        = spk_q;
  assign bus.Spike_peak   = speak_q;
  assign bus.Spike_index  = sidx_q;
  assign bus.Thresh       = thr_q;
  assign bus.Thresh_valid = tv_q;
  assign bus.Spike_count  = cnt_q;

endmodule

// File: tb/tb_neo_spike_detector.sv
// Bench for neo_spike_detector: table vectors, scripted corner
// sequences and a spike-event scoreboard.
module tb_neo_spike_detector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  neo_spike_detector_if ifc ();

  neo_spike_detector dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  typedef struct {
    logic [15:0] pk;
    logic [15:0] ix;
    logic [7:0]  cnt;
  } evt_t;

  typedef struct {
    logic        en;
    logic [15:0] d;
    logic        ev;
    logic [15:0] pk;
    logic [15:0] ix;
    logic [7:0]  cnt;
    logic        sp;
  } vec_t;

  evt_t exp_q[$];
  evt_t got;
  vec_t tbl[11];

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endfunction

  function automatic void push(int pk, int ix, int cnt);
    evt_t e;
    e.pk  = 16'(pk);
    e.ix  = 16'(ix);
    e.cnt = 8'(cnt);
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (ifc.Spike) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_spike actual=1 required=0");
      end else begin
        got = exp_q.pop_front();
        chk("spike_peak", int'(ifc.Spike_peak), int'(got.pk));
        chk("spike_index", int'(ifc.Spike_index), int'(got.ix));
        chk("spike_count", int'(ifc.Spike_count), int'(got.cnt));
      end
    end
  end

  task automatic send(input logic [15:0] d);
    ifc.Enable  = 1'b1;
    ifc.Data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.Enable = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.Enable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic train(input logic [15:0] a,
                       input logic [15:0] b);
    for (int i = 0; i < 256; i++) begin
      send(i[0] ? b : a);
      if (i == 254) chk("tv_before_end", int'(ifc.Thresh_valid), 0);
    end
    chk("tv_after_train", int'(ifc.Thresh_valid), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 16'd500,   1'b0, 16'd0,   16'd0,   8'd0, 1'b0};
    tbl[1]  = '{1'b1, 16'd900,   1'b0, 16'd0,   16'd0,   8'd0, 1'b0};
    tbl[2]  = '{1'b0, 16'd12345, 1'b0, 16'd0,   16'd0,   8'd0, 1'b0};
    tbl[3]  = '{1'b1, 16'd700,   1'b0, 16'd0,   16'd0,   8'd0, 1'b0};
    tbl[4]  = '{1'b1, 16'd300,   1'b1, 16'd900, 16'd257, 8'd1, 1'b1};
    tbl[5]  = '{1'b0, 16'd0,     1'b0, 16'd0,   16'd0,   8'd1, 1'b0};
    tbl[6]  = '{1'b1, 16'd1000,  1'b0, 16'd0,   16'd0,   8'd1, 1'b0};
    tbl[7]  = '{1'b1, 16'd1000,  1'b0, 16'd0,   16'd0,   8'd1, 1'b0};
    tbl[8]  = '{1'b1, 16'd1000,  1'b0, 16'd0,   16'd0,   8'd1, 1'b0};
    tbl[9]  = '{1'b1, 16'd1000,  1'b0, 16'd0,   16'd0,   8'd1, 1'b0};
    tbl[10] = '{1'b1, 16'd0,     1'b1, 16'd1000,16'd263, 8'd2, 1'b1};

    ifc.Enable     = 1'b0;
    ifc.Data_in    = '0;
    ifc.Scale      = 4'd4;
    ifc.Refractory = 8'd3;

    do_reset();
    chk("rst_spike", int'(ifc.Spike), 0);
    chk("rst_peak", int'(ifc.Spike_peak), 0);
    chk("rst_index", int'(ifc.Spike_index), 0);
    chk("rst_thresh", int'(ifc.Thresh), 0);
    chk("rst_tv", int'(ifc.Thresh_valid), 0);
    chk("rst_count", int'(ifc.Spike_count), 0);

    // basic spike, enable hold, refractory
    train(16'd100, 16'd100);
    chk("thresh_400", int'(ifc.Thresh), 400);
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].ev) push(int'(tbl[i].pk), int'(tbl[i].ix), int'(tbl[i].cnt));
      if (tbl[i].en) begin
        send(tbl[i].d);
      end else begin
        ifc.Data_in = tbl[i].d;
        idle();
      end
      chk($sformatf("tbl%0d_spike", i), int'(ifc.Spike), int'(tbl[i].sp));
      chk($sformatf("tbl%0d_count", i), int'(ifc.Spike_count), int'(tbl[i].cnt));
      chk($sformatf("tbl%0d_thresh", i), int'(ifc.Thresh), 400);
    end
    idle();

    // negative samples clamp during training
    ifc.Scale = 4'd1;
    do_reset();
    train(16'd200, 16'hff38);
    chk("thresh_clamp", int'(ifc.Thresh), 100);

    // threshold saturation
    ifc.Scale = 4'd15;
    do_reset();
    train(16'd20000, 16'd20000);
    chk("thresh_sat", int'(ifc.Thresh), 32767);
    send(16'd32767);
    send(16'd0);
    chk("sat_no_spike", int'(ifc.Spike_count), 0);

    // new threshold applies after the block-ending sample
    ifc.Scale      = 4'd0;
    ifc.Refractory = 8'd0;
    do_reset();
    train(16'd100, 16'd100);
    chk("thresh_scale0", int'(ifc.Thresh), 100);
    for (int i = 0; i < 255; i++) send(16'd50);
    push(300, 511, 1);
    send(16'd300);
    chk("thresh_blk2", int'(ifc.Thresh), 50);
    send(16'd60);
    chk("still_in_spike", int'(ifc.Spike), 0);
    send(16'd40);
    chk("blk_spike", int'(ifc.Spike), 1);
    push(60, 514, 2);
    send(16'd60);
    send(16'd0);
    chk("refr0_count", int'(ifc.Spike_count), 2);
    idle();

    // forced end at 64 samples, then refractory and a tie
    ifc.Scale      = 4'd1;
    ifc.Refractory = 8'd2;
    do_reset();
    train(16'd100, 16'd100);
    for (int i = 0; i < 70; i++) begin
      logic [15:0] v;
      v = 16'd200;
      if (i == 10) v = 16'd500;
      if (i == 63) v = 16'd600;
      if (i == 64 || i == 65) v = 16'd900;
      if (i == 66 || i == 69) v = 16'd300;
      if (i == 67 || i == 68) v = 16'd350;
      if (i == 63) push(600, 319, 1);
      send(v);
      if (i == 62) chk("no_early_end", int'(ifc.Spike_count), 0);
      if (i == 63) chk("forced_end", int'(ifc.Spike), 1);
    end
    push(350, 323, 2);
    send(16'd0);
    idle();

    // reset in the middle of a spike
    ifc.Refractory = 8'd0;
    do_reset();
    train(16'd100, 16'd100);
    send(16'd500);
    rst = 1'b1;
    ifc.Enable  = 1'b1;
    ifc.Data_in = 16'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_spike", int'(ifc.Spike), 0);
    chk("abort_count", int'(ifc.Spike_count), 0);
    chk("abort_tv", int'(ifc.Thresh_valid), 0);
    chk("abort_thresh", int'(ifc.Thresh), 0);
    chk("abort_peak", int'(ifc.Spike_peak), 0);
    chk("abort_index", int'(ifc.Spike_index), 0);
    idle();
    train(16'd100, 16'd100);
    push(500, 256, 1);
    send(16'd500);
    send(16'd0);
    idle();
    idle();

    chk("events_left", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neo_spike_detector.md
NEO_SPIKE_DETECTOR -- requirements
Module: neo_spike_detector

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; clk and rst are the only clock and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 Enable  input  1  sample strobe; Data_in is consumed on each rising edge where Enable=1.
REQ-005 Data_in  input  16 signed  NEO energy sample, i.e. the NEO Data_out stream.
REQ-006 Scale  input  4 unsigned  threshold multiplier; Scale=0 SHALL be treated as 1.
REQ-007 Refractory  input  8 unsigned  number of enabled samples ignored after a spike ends.
REQ-008 Spike  output  1  one-cycle event pulse.
REQ-009 Spike_peak  output  16 signed  maximum clamped sample of the last spike.
REQ-010 Spike_index  output  16 unsigned  sample index of that maximum.
REQ-011 Thresh  output  16 signed  active threshold.
REQ-012 Thresh_valid  output  1  high once the first training block completes.
REQ-013 Spike_count  output  8 unsigned  spikes since reset, saturating at 255.

Function
REQ-014 Each enabled sample SHALL be clamped: negative values become 0 before accumulation and comparison.
REQ-015 A 16-bit sample index SHALL count enabled samples from 0 after reset and wrap from 65535 to 0.
REQ-016 A 24-bit accumulator SHALL sum clamped samples over blocks of 256 enabled samples; at each block end, mean = sum>>8, Thresh = min(mean*Scale, 32767), and the accumulator restarts with the next sample.
REQ-017 A new Thresh SHALL first apply to the enabled sample after the block-ending sample; the block-ending sample is compared against the old Thresh.
REQ-018 States SHALL be TRAIN, ARMED, IN_SPIKE and REFRACT; reset enters TRAIN.
REQ-019 TRAIN -> ARMED at the end of the first block, with Thresh_valid=1 from that edge onward; no detection occurs in TRAIN.
REQ-020 In ARMED, a clamped sample strictly greater than Thresh SHALL enter IN_SPIKE and set peak=sample and peak_index=index.
REQ-021 In IN_SPIKE, a sample greater than peak SHALL update peak and index; ties keep the earlier index.
REQ-022 In IN_SPIKE, a sample <= Thresh, or the 64th consecutive sample of the spike, SHALL end the spike; the forced end includes that sample in peak tracking.
REQ-023 On spike end, Spike SHALL be high for exactly the next cycle; Spike_peak and Spike_index SHALL update on that same edge and hold until the next spike; Spike_count SHALL increment, saturating at 255.
REQ-024 On spike end, the block SHALL go to REFRACT loaded with Refractory, or straight to ARMED if Refractory=0.
REQ-025 REFRACT SHALL decrement once per enabled sample, ignore samples for detection, and go to ARMED when the counter reaches 0.
REQ-026 Accumulation and indexing SHALL continue in every state.
REQ-027 With Enable=0, all state, counters and outputs SHALL hold, except that Spike SHALL still deassert after its single cycle.
REQ-028 Latency: the Spike pulse SHALL appear on the first cycle after the spike-ending sample edge.

Reset
REQ-029 On rst=1, all outputs, the accumulator, the index, the peak register and the refractory counter SHALL become 0 and the state TRAIN on the same edge, including mid-spike; no Spike pulse is emitted for an aborted spike.
REQ-030 rst SHALL override Enable.

Verification
REQ-031 Scale=4, Refractory=3; send 256 samples of 100, then 500, 900, 700, 300 -> Thresh=400 and Thresh_valid=1 after sample 255; Spike pulses one cycle after 300 with Spike_peak=900, Spike_index=257, Spike_count=1.
REQ-032 Continue scenario 1 with 1000, 1000, 1000, then 1000 -> the first three samples are ignored (REFRACT), the fourth starts a new spike.
REQ-033 Training with alternating 200 and -200 for 256 samples, Scale=1 -> Thresh=100 (negatives clamped).
REQ-034 256 samples of 20000 with Scale=15 -> Thresh=32767; a following 32767 sample does not trigger.
REQ-035 Hold the signal above Thresh for 70 samples -> Spike fires after the 64th sample, then the REFRACT and re-arm behaviour of REQ-024/REQ-025 applies.
REQ-036 Assert rst while in IN_SPIKE -> no Spike pulse, all outputs 0, Thresh_valid=0, and training restarts at index 0.
